// File: rtl/snoop_pkg.sv
// Shared types and default address-field widths for the snoop responder.
package snoop_pkg;

  // Bus operations that can be snooped from other caches
  typedef enum logic [2:0] {
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RWIM       = 3'd4
  } bus_op_e;

  // Answer returned to the bus for one snoop
  typedef enum logic [1:0] {
    HIT   = 2'd0,
    HITM  = 2'd1,
    NOHIT = 2'd2
  } snp_result_e;

  // MESI line state as held in the shadow
  typedef enum logic [1:0] {
    I = 2'd0,
    E = 2'd1,
    S = 2'd2,
    M = 2'd3
  } mesi_e;

  // Default geometry: 32-bit address, 64 B lines, 16 sets, 8 ways
  localparam int ADDRESS_BITS_DEF = 32;
  localparam int OFFSET_BITS_DEF  = 6;
  localparam int INDEX_BITS_DEF   = 4;
  localparam int WAYS_DEF         = 8;
  localparam int TAG_BITS_DEF     = ADDRESS_BITS_DEF - INDEX_BITS_DEF - OFFSET_BITS_DEF;

endpackage

// File: rtl/snoop_mesi_next.sv
// MESI transition table for one snooped operation against the local line state.
module snoop_mesi_next
  import snoop_pkg::*;
(
  input  bus_op_e     i_op,
  input  mesi_e       i_state,
  output mesi_e       o_next,
  output snp_result_e o_result,
  output logic        o_needWb,
  output logic        o_err
);

  // Default is "not present, untouched"; each op overrides only the cases it acts on
  always_comb begin
    o_next   = i_state;
    o_result = NOHIT;
    o_needWb = 1'b0;
    o_err    = 1'b0;
    case (i_op)
      READ: begin
        case (i_state)
          M: begin
            o_next   = S;
            o_result = HITM;
            o_needWb = 1'b1;
          end
          E, S: begin
            o_next   = S;
            o_result = HIT;
          end
          default: ;
        endcase
      end
      RWIM: begin
        case (i_state)
          M: begin
            o_next   = I;
            o_result = HITM;
            o_needWb = 1'b1;
          end
          E, S: begin
            o_next   = I;
            o_result = HIT;
          end
          default: ;
        endcase
      end
      INVALIDATE: begin
        case (i_state)
          S: begin
            o_next   = I;
            o_result = HIT;
          end
          M, E: o_err = 1'b1;
          default: ;
        endcase
      end
      WRITE: begin
        o_err = (i_state == M);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder: tag + MESI shadow of the local cache, answers snooped bus ops.
module snoop_responder
  import snoop_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
  parameter int OFFSET_BITS  = OFFSET_BITS_DEF,
  parameter int INDEX_BITS   = INDEX_BITS_DEF,
  parameter int WAYS         = WAYS_DEF,
  parameter int TAG_BITS     = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    snp_valid,
  output logic                    snp_ready,
  input  logic [2:0]              snp_op,
  input  logic [ADDRESS_BITS-1:0] snp_addr,
  input  logic                    fill_valid,
  output logic                    fill_ready,
  input  logic [ADDRESS_BITS-1:0] fill_addr,
  input  logic [$clog2(WAYS)-1:0] fill_way,
  input  logic [1:0]              fill_state,
  input  logic                    clr,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [ADDRESS_BITS-1:0] wb_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_result,
  output logic                    proto_err,
  output logic [31:0]             snoop_cnt,
  output logic [31:0]             hitm_cnt
);

  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WAY_BITS = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, RESP} fsm_e;

  fsm_e                           r_state;
  logic [2:0]                     r_op;
  logic [ADDRESS_BITS-1:OFFSET_BITS] r_line;
  snp_result_e                    r_result;
  logic                           r_wbValid;
  logic [ADDRESS_BITS-1:0]        r_wbAddr;
  logic                           r_rspValid;
  logic [31:0]                    r_snoopCnt;
  logic [31:0]                    r_hitmCnt;
  logic [TAG_BITS-1:0]            r_tag  [SETS][WAYS];
  mesi_e                          r_mesi [SETS][WAYS];

  logic [INDEX_BITS-1:0]          w_snpIndex;
  logic [TAG_BITS-1:0]            w_snpTag;
  logic [INDEX_BITS-1:0]          w_fillIndex;
  logic [TAG_BITS-1:0]            w_fillTag;
  logic                           w_hit;
  logic [WAY_BITS-1:0]            w_hitWay;
  mesi_e                          w_curState;
  mesi_e                          w_next;
  snp_result_e                    w_result;
  logic                           w_needWb;
  logic                           w_err;
  logic                           w_unusedOffsets;

  assign w_snpIndex      = r_line[OFFSET_BITS +: INDEX_BITS];
  assign w_snpTag        = r_line[ADDRESS_BITS-1 -: TAG_BITS];
  assign w_fillIndex     = fill_addr[OFFSET_BITS +: INDEX_BITS];
  assign w_fillTag       = fill_addr[ADDRESS_BITS-1 -: TAG_BITS];
  assign w_unusedOffsets = ^{snp_addr[OFFSET_BITS-1:0], fill_addr[OFFSET_BITS-1:0]};

  assign snp_ready  = (r_state == IDLE) && !clr && !fill_valid;
  assign fill_ready = (r_state == IDLE) && !clr;
  assign wb_valid   = r_wbValid;
  assign wb_addr    = r_wbAddr;
  assign rsp_valid  = r_rspValid;
  assign rsp_result = r_result;
  assign proto_err  = (r_state == LOOKUP) && w_err;
  assign snoop_cnt  = r_snoopCnt;
  assign hitm_cnt   = r_hitmCnt;

  // Tag compare across the set; scanning downward lets the lowest matching way win
  always_comb begin
    w_hit      = 1'b0;
    w_hitWay   = '0;
    w_curState = I;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_mesi[w_snpIndex][w] != I && r_tag[w_snpIndex][w] == w_snpTag) begin
        w_hit      = 1'b1;
        w_hitWay   = WAY_BITS'(w);
        w_curState = r_mesi[w_snpIndex][w];
      end
    end
  end

  snoop_mesi_next u_mesiNext (
    .i_op     (bus_op_e'(r_op)),
    .i_state  (w_curState),
    .o_next   (w_next),
    .o_result (w_result),
    .o_needWb (w_needWb),
    .o_err    (w_err)
  );

  // Responder FSM plus shadow updates from clr, fill and committed snoop transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_line     <= '0;
      r_result   <= HIT;
      r_wbValid  <= 1'b0;
      r_wbAddr   <= '0;
      r_rspValid <= 1'b0;
      r_snoopCnt <= '0;
      r_hitmCnt  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_mesi[s][w] <= I;
          r_tag[s][w]  <= '0;
        end
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (clr) begin
            for (int s = 0; s < SETS; s++) begin
              for (int w = 0; w < WAYS; w++) begin
                r_mesi[s][w] <= I;
              end
            end
          end else if (fill_valid) begin
            r_tag[w_fillIndex][fill_way]  <= w_fillTag;
            r_mesi[w_fillIndex][fill_way] <= mesi_e'(fill_state);
          end else if (snp_valid) begin
            r_op       <= snp_op;
            r_line     <= snp_addr[ADDRESS_BITS-1:OFFSET_BITS];
            r_snoopCnt <= r_snoopCnt + 32'd1;
            r_state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_mesi[w_snpIndex][w_hitWay] <= w_next;
          end
          if (w_result == HITM) begin
            r_hitmCnt <= r_hitmCnt + 32'd1;
          end
          r_result <= w_result;
          if (w_needWb) begin
            r_wbValid <= 1'b1;
            r_wbAddr  <= {r_line, {OFFSET_BITS{1'b0}}};
            r_state   <= WB;
          end else begin
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end
        end
        WB: begin
          if (wb_ready) begin
            r_wbValid  <= 1'b0;
            r_rspValid <= 1'b1;
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder with a transaction-level shadow model.
module tb_snoop_responder;
  import snoop_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        snp_valid;
  logic        snp_ready;
  logic [2:0]  snp_op;
  logic [31:0] snp_addr;
  logic        fill_valid;
  logic        fill_ready;
  logic [31:0] fill_addr;
  logic [2:0]  fill_way;
  logic [1:0]  fill_state;
  logic        clr;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_result;
  logic        proto_err;
  logic [31:0] snoop_cnt;
  logic [31:0] hitm_cnt;

  // Model of the shadow: tag and MESI value per set/way, as plain integers
  int unsigned mTag   [16][8];
  int          mState [16][8];

  // Expected outputs for the current cycle, maintained by the driver
  logic        eSnpReady, eFillReady, eWbValid, eRspValid, eErr;
  logic [31:0] eWbAddr, eSnoopCnt, eHitmCnt;
  logic [1:0]  eResult;

  int          errors = 0;
  int          checks = 0;
  logic        chkOn  = 1'b0;
  logic [1:0]  lastRsp = 2'd3;

  always #5 clk = ~clk;

  snoop_responder dut (
    .clk        (clk),
    .rst        (rst),
    .snp_valid  (snp_valid),
    .snp_ready  (snp_ready),
    .snp_op     (snp_op),
    .snp_addr   (snp_addr),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_addr  (fill_addr),
    .fill_way   (fill_way),
    .fill_state (fill_state),
    .clr        (clr),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .proto_err  (proto_err),
    .snoop_cnt  (snoop_cnt),
    .hitm_cnt   (hitm_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare the DUT against the model's expectation on the falling edge
  always @(negedge clk) begin
    if (chkOn) begin
      checkOutput("snp_ready",  {31'd0, snp_ready},  {31'd0, eSnpReady});
      checkOutput("fill_ready", {31'd0, fill_ready}, {31'd0, eFillReady});
      checkOutput("wb_valid",   {31'd0, wb_valid},   {31'd0, eWbValid});
      checkOutput("rsp_valid",  {31'd0, rsp_valid},  {31'd0, eRspValid});
      checkOutput("proto_err",  {31'd0, proto_err},  {31'd0, eErr});
      checkOutput("snoop_cnt",  snoop_cnt, eSnoopCnt);
      checkOutput("hitm_cnt",   hitm_cnt,  eHitmCnt);
      if (eWbValid)  checkOutput("wb_addr", wb_addr, eWbAddr);
      if (eRspValid) checkOutput("rsp_result", {30'd0, rsp_result}, {30'd0, eResult});
      if (rsp_valid) lastRsp = rsp_result;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int idxOf(input logic [31:0] a);
    return int'((a >> 6) & 32'hF);
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] a);
    return a >> 10;
  endfunction

  // Protocol rules: what the bus must see and where the line ends up
  task automatic rule(input int op, input int st, output int res, output int nxt,
                      output bit wb, output bit err);
    res = NOHIT; nxt = st; wb = 1'b0; err = 1'b0;
    if (op == READ || op == RWIM) begin
      if (st != I) begin
        res = (st == M) ? HITM : HIT;
        wb  = (st == M);
        nxt = (op == READ) ? S : I;
      end
    end else if (op == INVALIDATE) begin
      if (st == S) begin
        res = HIT;
        nxt = I;
      end else if (st != I) begin
        err = 1'b1;
      end
    end else if (op == WRITE) begin
      err = (st == M);
    end
  endtask

  task automatic setIdleExp();
    eSnpReady  = !clr && !fill_valid;
    eFillReady = !clr;
    eWbValid   = 1'b0;
    eRspValid  = 1'b0;
    eErr       = 1'b0;
  endtask

  task automatic modelReset();
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 8; w++) begin
        mTag[s][w]   = 0;
        mState[s][w] = I;
      end
    eSnoopCnt = 0;
    eHitmCnt  = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input int way, input int st);
    fill_valid = 1'b1; fill_addr = addr; fill_way = 3'(way); fill_state = 2'(st);
    setIdleExp();
    step();
    fill_valid = 1'b0;
    mTag[idxOf(addr)][way]   = tagOf(addr);
    mState[idxOf(addr)][way] = st;
    setIdleExp();
  endtask

  task automatic applySnoop(input int op, input logic [31:0] addr, input int wbHold,
                            input int rspHold, input bit abortInWb);
    int ix, way, st, res, nxt;
    int unsigned tg;
    bit wb, err;
    ix = idxOf(addr); tg = tagOf(addr); way = -1;
    for (int w = 0; w < 8; w++)
      if (way < 0 && mState[ix][w] != I && mTag[ix][w] == tg) way = w;
    st = (way < 0) ? int'(I) : mState[ix][way];
    rule(op, st, res, nxt, wb, err);
    snp_valid = 1'b1; snp_op = 3'(op); snp_addr = addr;
    setIdleExp();
    step();
    snp_valid = 1'b0;
    eSnpReady = 1'b0; eFillReady = 1'b0; eErr = err;
    eSnoopCnt = eSnoopCnt + 1;
    step();
    if (way >= 0) mState[ix][way] = nxt;
    if (res == HITM) eHitmCnt = eHitmCnt + 1;
    eErr = 1'b0;
    if (wb) begin
      eWbValid = 1'b1;
      eWbAddr  = addr & 32'hFFFF_FFC0;
      for (int k = 0; k < wbHold; k++) begin
        wb_ready = 1'b0;
        step();
      end
      if (abortInWb) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        modelReset();
        setIdleExp();
        return;
      end
      wb_ready = 1'b1;
      step();
      wb_ready = 1'b0;
      eWbValid = 1'b0;
    end
    eRspValid = 1'b1;
    eResult   = 2'(res);
    for (int k = 0; k < rspHold; k++) begin
      rsp_ready = 1'b0;
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    setIdleExp();
  endtask

  // Directed scenarios
  initial begin
    rst = 1'b1; snp_valid = 0; snp_op = 0; snp_addr = 0; fill_valid = 0; fill_addr = 0;
    fill_way = 0; fill_state = 0; clr = 0; wb_ready = 0; rsp_ready = 0;
    eResult = 0; eWbAddr = 0;
    modelReset();
    setIdleExp();
    step();
    chkOn = 1'b1;
    checkOutput("reset_wb_addr", wb_addr, 32'h0);
    checkOutput("reset_rsp_result", {30'd0, rsp_result}, 32'h0);
    step();
    rst = 1'b0;
    step();

    // Modified line read by another cache: HITM with writeback
    applyStimulus(32'h0000_1240, 2, M);
    applySnoop(READ, 32'h0000_1240, 0, 0, 1'b0);
    checkOutput("t1_hitm_cnt", hitm_cnt, 32'd1);
    checkOutput("t1_result", {30'd0, lastRsp}, {30'd0, HITM});
    applySnoop(READ, 32'h0000_1240, 0, 0, 1'b0);
    checkOutput("t1_now_shared", {30'd0, lastRsp}, {30'd0, HIT});

    // Exclusive line, RWIM with a slow consumer, then the line is gone
    applyStimulus(32'h0000_2380, 0, E);
    applySnoop(RWIM, 32'h0000_2380, 0, 3, 1'b0);
    checkOutput("t2_rwim", {30'd0, lastRsp}, {30'd0, HIT});
    applySnoop(READ, 32'h0000_2380, 0, 0, 1'b0);
    checkOutput("t2_gone", {30'd0, lastRsp}, {30'd0, NOHIT});

    // Invalidate of shared vs. exclusive line
    applyStimulus(32'h0000_3440, 1, S);
    applySnoop(INVALIDATE, 32'h0000_3440, 0, 0, 1'b0);
    checkOutput("t3_inv_s", {30'd0, lastRsp}, {30'd0, HIT});
    applyStimulus(32'h0000_3440, 1, E);
    applySnoop(INVALIDATE, 32'h0000_3440, 0, 1, 1'b0);
    checkOutput("t3_inv_e", {30'd0, lastRsp}, {30'd0, NOHIT});
    applySnoop(READ, 32'h0000_3440, 0, 0, 1'b0);
    checkOutput("t3_still_e", {30'd0, lastRsp}, {30'd0, HIT});

    // clr beats fill beats snoop, all presented together
    clr = 1'b1; fill_valid = 1'b1; fill_addr = 32'h0000_5000; fill_way = 3'd3; fill_state = S;
    snp_valid = 1'b1; snp_op = READ; snp_addr = 32'h0000_5000;
    setIdleExp();
    step();
    clr = 1'b0;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 8; w++) mState[s][w] = I;
    setIdleExp();
    step();
    fill_valid = 1'b0;
    mTag[0][3] = 32'h14; mState[0][3] = S;
    applySnoop(READ, 32'h0000_5000, 0, 0, 1'b0);
    checkOutput("t4_fill_seen", {30'd0, lastRsp}, {30'd0, HIT});
    applySnoop(WRITE, 32'h0000_1240, 0, 0, 1'b0);
    checkOutput("t4_cleared", {30'd0, lastRsp}, {30'd0, NOHIT});

    // Reset while waiting on a writeback abandons the snoop
    applyStimulus(32'h0000_7080, 4, M);
    applySnoop(READ, 32'h0000_7080, 2, 0, 1'b1);
    checkOutput("t5_snoop_cnt", snoop_cnt, 32'd0);
    checkOutput("t5_wb_addr", wb_addr, 32'd0);
    checkOutput("t5_snp_ready", {31'd0, snp_ready}, 32'd1);
    step();
    applySnoop(READ, 32'h0000_7080, 0, 0, 1'b0);
    checkOutput("t5_entry_i", {30'd0, lastRsp}, {30'd0, NOHIT});

    // Full set with no matching tag, then duplicate tags (lowest way wins)
    for (int w = 0; w < 8; w++)
      applyStimulus(((w + 1) << 10) | (5 << 6), w, (w % 3 == 0) ? M : ((w % 3 == 1) ? E : S));
    applySnoop(READ, (32'h20 << 10) | (5 << 6), 0, 0, 1'b0);
    checkOutput("t6_miss", {30'd0, lastRsp}, {30'd0, NOHIT});
    checkOutput("t6_snoop_cnt", snoop_cnt, 32'd2);
    applyStimulus((2 << 10) | (5 << 6), 6, M);
    applySnoop(READ, (2 << 10) | (5 << 6), 0, 0, 1'b0);
    checkOutput("t6_lowest_way", {30'd0, lastRsp}, {30'd0, HIT});
    applySnoop(WRITE, (1 << 10) | (5 << 6), 0, 0, 1'b0);
    applySnoop(RWIM, (4 << 10) | (5 << 6), 1, 2, 1'b0);
    checkOutput("t6_rwim_m", {30'd0, lastRsp}, {30'd0, HITM});
    checkOutput("t6_hitm_cnt", hitm_cnt, 32'd1);
    step();

    chkOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
